filter_out_decimator: RTL and testbench
=======================================

// Module: filter_out_decimator
// PURPOSE
//   Consumes the signed 17-bit sample stream from the FIR filter and averages each block of
//   DEC consecutive valid samples (accumulate-and-dump), rounds, saturates to OUT_W, and
//   buffers the results in a small FIFO with a valid/ready output handshake. It sits directly
//   downstream of the filter and feeds the output writer / next rate stage.
// PARAMETERS
//   DATA_W     17  input sample width (two's complement)
//   LOG2_DEC   2   log2 of decimation factor; DEC = 2**LOG2_DEC (LOG2_DEC >= 1)
//   OUT_W      16  output sample width (two's complement, OUT_W <= DATA_W)
//   FIFO_AW    2   FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//   clk         in   1           system clock, all state on rising edge
//   rst         in   1           asynchronous, active-low reset
//   in_valid    in   1           data_in carries a valid filter sample this cycle
//   data_in     in   DATA_W      signed filter output sample
//   out_ready   in   1           consumer accepts out_data this cycle
//   out_valid   out  1           FIFO non-empty; out_data is valid
//   out_data    out  OUT_W       signed decimated sample at FIFO head
//   fifo_count  out  FIFO_AW+1   number of entries held (0..2**FIFO_AW)
//   ovf         out  1           sticky: a result was dropped because the FIFO was full
//   clr_ovf     in   1           synchronous clear of ovf
// BEHAVIOUR
// - Reset (rst=0): acc=0, cnt=0, FIFO empty, rd/wr pointers 0, all FIFO entries 0,
//   out_valid=0, out_data=0, fifo_count=0, ovf=0. Reset asserted mid-block discards the partial sum.
// - Accumulator: DATA_W+LOG2_DEC bits signed; cnt counts 0..DEC-1; in_valid=0 -> no change.
// - in_valid=1 and cnt<DEC-1: acc <= acc + data_in; cnt <= cnt+1.
// - in_valid=1 and cnt==DEC-1 (dump): sum = acc + data_in; acc <= 0; cnt <= 0;
//   rnd = (sum + 2**(LOG2_DEC-1)) >>> LOG2_DEC (round half toward +inf, arithmetic shift,
//   computed at DATA_W+LOG2_DEC+1 bits, no intermediate overflow);
//   res = rnd clamped to [-2**(OUT_W-1), 2**(OUT_W-1)-1]; res is pushed on the same edge.
// - Latency: result visible at out_data/out_valid one cycle after the edge sampling the DEC-th
//   input when the FIFO was empty (push on that edge, output from registered FIFO state).
// - FIFO: out_data = entry at rd pointer; out_valid = (fifo_count != 0).
//   Pop when out_valid && out_ready. Push when dump && (count < depth || pop this cycle).
//   Simultaneous push+pop: count unchanged, order preserved; pointers wrap modulo depth.
//   Push on empty FIFO with out_ready=1: data appears next cycle, not same cycle (no bypass).
//   out_ready while empty: ignored, no state change.
// - Full and dump without pop: result dropped, FIFO contents unchanged, ovf <= 1.
//   ovf clears only on reset or clr_ovf=1; if a drop and clr_ovf coincide, ovf stays 1.
// - out_data holds last head value while out_valid=0 (bench must not check it then).
// TESTING (DEC=4, DATA_W=17, OUT_W=16, depth 4)
// 1. Reset: hold rst=0 -> out_valid=0, out_data=0, fifo_count=0, ovf=0; release, idle -> unchanged.
// 2. Basic: in_valid=1, data 100,200,300,400, out_ready=1 -> next cycle out_valid=1, out_data=250,
//    popped one cycle later, fifo_count back to 0.
// 3. Rounding: -1,-1,-1,-2 -> -1; 1,1,0,0 -> 1; 2,2,2,-4 -> 1 (sum 2 +2 =4 >>>2).
// 4. Saturation: 4x +65535 -> 32767; 4x -65536 -> -32768; ovf stays 0.
// 5. Backpressure: out_ready=0, 20 valid samples (5 results 10,20,30,40,50) -> fifo_count=4,
//    ovf=1, 50 dropped; out_ready=1 -> 10,20,30,40 in order; clr_ovf pulse -> ovf=0.
// 6. Gaps/reset: in_valid toggled 1,0,1,0.. over samples 8,8,8,8 -> single result 8; feed two
//    samples 1000,1000, assert rst, then 4,4,4,4 -> result 4 (partial sum discarded).

Source files
------------

// File: rtl/filter_out_decimator.sv
// ---------------------------------------------------------------------------
// filter_out_decimator
//   Averages each block of DEC = 2**LOG2_DEC valid filter samples
//   (accumulate-and-dump). Each block result is rounded half toward +inf,
//   saturated to OUT_W bits and then pushed into a small FIFO. The FIFO
//   drives a valid/ready output handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    data_in holds a valid sample this cycle
//   data_in     signed DATA_W-bit filter sample
//   out_ready   consumer accepts out_data this cycle
//   clr_ovf     synchronous clear of the sticky overflow flag
//   out_valid   FIFO non-empty (registered)
//   out_data    signed OUT_W-bit sample at FIFO head (registered)
//   fifo_count  number of entries held, 0..2**FIFO_AW (registered)
//   ovf         sticky: a result was dropped on a full FIFO (registered)
// ---------------------------------------------------------------------------
module filter_out_decimator #(
   parameter int unsigned DATA_W   = 17,
   parameter int unsigned LOG2_DEC = 2,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned FIFO_AW  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     out_ready,
   input  logic                     clr_ovf,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [FIFO_AW:0]         fifo_count,
   output logic                     ovf
);

   localparam int unsigned DEC    = 1 << LOG2_DEC;
   localparam int unsigned ACC_W  = DATA_W + LOG2_DEC;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned DEPTH  = 1 << FIFO_AW;
   localparam int unsigned CNT_W  = LOG2_DEC;
   localparam int unsigned FCNT_W = FIFO_AW + 1;

   localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(DEC - 1);
   localparam logic [FCNT_W-1:0]        FULL_CNT = FCNT_W'(DEPTH);
   localparam logic [SUM_W-1:0]         HALF     = SUM_W'(DEC / 2);
   localparam logic signed [SUM_W-1:0]  OUT_MAX  =
      {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0]  OUT_MIN  =
      {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // State
   logic signed [ACC_W-1:0]  acc_q,       acc_d;
   logic [CNT_W-1:0]         cnt_q,       cnt_d;
   logic [OUT_W-1:0]         mem_q [DEPTH], mem_d [DEPTH];
   logic [FIFO_AW-1:0]       rd_ptr_q,    rd_ptr_d;
   logic [FIFO_AW-1:0]       wr_ptr_q,    wr_ptr_d;
   logic [FCNT_W-1:0]        count_q,     count_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]  out_data_q,  out_data_d;
   logic                     ovf_q,       ovf_d;

   // Datapath intermediates
   logic signed [SUM_W-1:0]  sum_c;
   logic signed [SUM_W-1:0]  rsum_c;
   logic signed [SUM_W-1:0]  rnd_c;
   logic signed [OUT_W-1:0]  res_c;
   logic                     dump_c;
   logic                     pop_c;
   logic                     push_c;
   logic                     drop_c;

   // Widen the block sum by one bit so that adding the rounding constant
   // cannot overflow. The accumulator holds at most DEC-1 samples, so it
   // cannot overflow ACC_W bits.
   always_comb begin
      sum_c  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
             + {{(SUM_W-DATA_W){data_in[DATA_W-1]}}, data_in};
      rsum_c = sum_c + HALF;
      rnd_c  = rsum_c >>> LOG2_DEC;
      if (rnd_c > OUT_MAX) begin
         res_c = OUT_MAX[OUT_W-1:0];
      end else if (rnd_c < OUT_MIN) begin
         res_c = OUT_MIN[OUT_W-1:0];
      end else begin
         res_c = rnd_c[OUT_W-1:0];
      end
   end

   // Accumulator and block counter
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      dump_c = 1'b0;
      if (in_valid) begin
         if (cnt_q == LAST_CNT) begin
            dump_c = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
         end else begin
            acc_d  = sum_c[ACC_W-1:0];
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   // FIFO control. A full FIFO still accepts a push when it pops on the same edge.
   always_comb begin
      pop_c  = out_valid_q && out_ready;
      push_c = dump_c && ((count_q != FULL_CNT) || pop_c);
      drop_c = dump_c && !push_c;

      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (push_c) begin
         mem_d[wr_ptr_q] = res_c;
         wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end
      if (push_c && !pop_c) begin
         count_d = count_q + FCNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - FCNT_W'(1);
      end
   end

   // Registered output view of the next FIFO head. When the FIFO empties,
   // the last head value is held.
   always_comb begin
      out_valid_d = (count_d != '0);
      out_data_d  = out_data_q;
      if (out_valid_d) begin
         out_data_d = mem_d[rd_ptr_d];
      end
   end

   // Sticky overflow. A drop on the same edge as a clear wins.
   always_comb begin
      ovf_d = ovf_q;
      if (drop_c) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign fifo_count = count_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_filter_out_decimator.sv
// ---------------------------------------------------------------------------
// tb_filter_out_decimator
//   Self-checking bench for filter_out_decimator (DEC=4, depth 4).
//   Block stimulus comes from a table of vectors. Expected results go into a
//   scoreboard queue and are compared when the output handshake fires.
// ---------------------------------------------------------------------------
module tb_filter_out_decimator;

   localparam int unsigned DATA_W   = 17;
   localparam int unsigned LOG2_DEC = 2;
   localparam int unsigned OUT_W    = 16;
   localparam int unsigned FIFO_AW  = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic signed [DATA_W-1:0] data_in;
   logic                     out_ready;
   logic                     clr_ovf;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;
   logic [FIFO_AW:0]         fifo_count;
   logic                     ovf;

   filter_out_decimator #(
      .DATA_W   (DATA_W),
      .LOG2_DEC (LOG2_DEC),
      .OUT_W    (OUT_W),
      .FIFO_AW  (FIFO_AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .data_in    (data_in),
      .out_ready  (out_ready),
      .clr_ovf    (clr_ovf),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .fifo_count (fifo_count),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s [4];
      int exp_out;
   } vec_t;

   vec_t vecs [10];
   int   sb_q [$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // One clock. Sample at the negedge, then return #1 after the posedge.
   task automatic tick();
      int e;
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d expected none at %0t",
                     int'(out_data), $time);
         end else begin
            e = sb_q.pop_front();
            chk("out_data", int'(out_data), e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int v);
      in_valid = 1'b1;
      data_in  = DATA_W'(v);
      tick();
      in_valid = 1'b0;
   endtask

   // Four equal samples; their average is v.
   task automatic block(input int v);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) sb_q.push_back(v);
         drive(v);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
      chk({name, "_drained"}, sb_q.size(), 0);
      chk({name, "_count0"}, int'(fifo_count), 0);
   endtask

   initial begin
      vecs[0] = '{s: '{100, 200, 300, 400},         exp_out: 250};
      vecs[1] = '{s: '{-1, -1, -1, -2},             exp_out: -1};
      vecs[2] = '{s: '{1, 1, 0, 0},                 exp_out: 1};
      vecs[3] = '{s: '{2, 2, 2, -4},                exp_out: 1};
      vecs[4] = '{s: '{65535, 65535, 65535, 65535}, exp_out: 32767};
      vecs[5] = '{s: '{-65536, -65536, -65536, -65536}, exp_out: -32768};
      vecs[6] = '{s: '{3, 0, 0, 0},                 exp_out: 1};
      vecs[7] = '{s: '{-2, 0, 0, 0},                exp_out: 0};
      vecs[8] = '{s: '{-3, 0, 0, 0},                exp_out: -1};
      vecs[9] = '{s: '{-40000, -40000, 10, -5},     exp_out: -19999};

      rst = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

      // Values held in reset and after release while idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst = 1'b1;
      repeat (3) tick();
      chk("idle_out_valid", int'(out_valid), 0);
      chk("idle_out_data", int'(out_data), 0);
      chk("idle_fifo_count", int'(fifo_count), 0);
      chk("idle_ovf", int'(ovf), 0);

      // Table vectors with one-cycle latency and immediate pop
      out_ready = 1'b1;
      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < 4; i++) begin
            if (i == 3) sb_q.push_back(vecs[v].exp_out);
            drive(vecs[v].s[i]);
         end
         chk("latency_valid", int'(out_valid), 1);
         chk("latency_count", int'(fifo_count), 1);
         tick();
         chk("popped_count", int'(fifo_count), 0);
         chk("popped_valid", int'(out_valid), 0);
         chk("no_ovf", int'(ovf), 0);
      end
      chk("table_sb_empty", sb_q.size(), 0);

      // Full FIFO that pushes and pops on the same edge: no drop
      out_ready = 1'b0;
      block(-7); block(7); block(-300); block(300);
      chk("full_count", int'(fifo_count), 4);
      for (int i = 0; i < 3; i++) drive(11);
      out_ready = 1'b1;
      sb_q.push_back(11);
      drive(11);
      chk("pushpop_count", int'(fifo_count), 4);
      chk("pushpop_no_ovf", int'(ovf), 0);
      drain("pushpop");

      // Backpressure: the fifth result is dropped
      out_ready = 1'b0;
      block(10); block(20); block(30); block(40);
      for (int i = 0; i < 4; i++) drive(50);
      chk("bp_count", int'(fifo_count), 4);
      chk("bp_ovf", int'(ovf), 1);
      out_ready = 1'b1;
      drain("bp");
      chk("bp_ovf_sticky", int'(ovf), 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", int'(ovf), 0);

      // Gaps in in_valid do not advance the block
      for (int i = 0; i < 4; i++) begin
         if (i == 3) sb_q.push_back(8);
         drive(8);
         tick();
      end
      drain("gaps");

      // A reset in mid-block discards the partial sum
      drive(1000);
      drive(1000);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst_count", int'(fifo_count), 0);
      block(4);
      drain("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
